// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit completion FIFOs drained round-robin onto a registered CDB
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              alu_done_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mul_done_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    output logic              mul_ready_o,
    input  logic              lsu_done_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [1:0]        cdb_src_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0]  tag_mem  [3][DEPTH];
    logic [DATA_W-1:0] data_mem [3][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [3];
    logic [PTR_W-1:0]  rd_ptr   [3];
    logic [CNT_W-1:0]  count    [3];

    logic [2:0]        in_done;
    logic [TAG_W-1:0]  in_tag   [3];
    logic [DATA_W-1:0] in_data  [3];

    logic [2:0] ready;
    logic [2:0] req;
    logic [2:0] push;
    logic [2:0] pop;
    logic [1:0] rr;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [2:0] cand;

    assign in_done = {lsu_done_i, mul_done_i, alu_done_i};
    assign in_tag[0]  = alu_tag_i;
    assign in_tag[1]  = mul_tag_i;
    assign in_tag[2]  = lsu_tag_i;
    assign in_data[0] = alu_data_i;
    assign in_data[1] = mul_data_i;
    assign in_data[2] = lsu_data_i;

    // Ready looks only at the registered count; a same-cycle pop earns no credit.
    always_comb begin
        ready = '0;
        req   = '0;
        push  = '0;
        for (int k = 0; k < 3; k++) begin
            ready[k] = (count[k] < FULL_CNT);
            req[k]   = (count[k] != '0);
            push[k]  = in_done[k] & ready[k] & ~flush_i;
        end
    end

    assign alu_ready_o = ready[0];
    assign mul_ready_o = ready[1];
    assign lsu_ready_o = ready[2];

    // Search order starts at rr and wraps modulo 3.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, rr} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!gnt_valid && req[cand[1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (gnt_valid && !flush_i) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 3; k++) begin
            if (push[k]) begin
                tag_mem[k][wr_ptr[k]]  <= in_tag[k];
                data_mem[k][wr_ptr[k]] <= in_data[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < 3; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < 3; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + CNT_W'(1);
                end else if (pop[k] && !push[k]) begin
                    count[k] <= count[k] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr         <= 2'd0;
            cdb_en_o   <= 1'b0;
            cdb_tag_o  <= '0;
            cdb_data_o <= '0;
            cdb_src_o  <= 2'd0;
        end else begin
            cdb_en_o <= gnt_valid & ~flush_i;
            if (gnt_valid && !flush_i) begin
                rr         <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
                cdb_tag_o  <= tag_mem[gnt_idx][rd_ptr[gnt_idx]];
                cdb_data_o <= data_mem[gnt_idx][rd_ptr[gnt_idx]];
                cdb_src_o  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        alu_done_i, mul_done_i, lsu_done_i;
    logic [4:0]  alu_tag_i, mul_tag_i, lsu_tag_i;
    logic [31:0] alu_data_i, mul_data_i, lsu_data_i;
    logic        alu_ready_o, mul_ready_o, lsu_ready_o;
    logic        cdb_en_o;
    logic [4:0]  cdb_tag_o;
    logic [31:0] cdb_data_o;
    logic [1:0]  cdb_src_o;

    cdb_arbiter #(.TAG_W(5), .DATA_W(32), .DEPTH(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .alu_done_i(alu_done_i), .alu_tag_i(alu_tag_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
        .mul_done_i(mul_done_i), .mul_tag_i(mul_tag_i), .mul_data_i(mul_data_i), .mul_ready_o(mul_ready_o),
        .lsu_done_i(lsu_done_i), .lsu_tag_i(lsu_tag_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
        .cdb_en_o(cdb_en_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic       ad;
        logic [4:0] at;
        logic       md;
        logic [4:0] mt;
        logic       ld;
        logic [4:0] lt;
        logic       en;
        logic [4:0] tag;
        logic [1:0] src;
    } vec_t;

    ent_t q0[$];
    ent_t q1[$];
    ent_t q2[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mul_bcast = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mkdat(input int u, input logic [4:0] t);
        return 32'hC0DE_0000 | (32'(u) << 8) | {27'd0, t};
    endfunction

    task automatic drive(input logic ad, input logic [4:0] at, input logic md, input logic [4:0] mt,
                         input logic ld, input logic [4:0] lt, input logic fl);
        alu_done_i = ad; alu_tag_i = at; alu_data_i = mkdat(0, at);
        mul_done_i = md; mul_tag_i = mt; mul_data_i = mkdat(1, mt);
        lsu_done_i = ld; lsu_tag_i = lt; lsu_data_i = mkdat(2, lt);
        flush_i    = fl;
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Record accepted pushes, clock once, then score any broadcast and the ready flags.
    task automatic step();
        ent_t e;
        logic got;
        if (reset_i && flush_i) begin
            clear_q();
        end else if (reset_i) begin
            if (alu_done_i && alu_ready_o) q0.push_back({alu_tag_i, alu_data_i});
            if (mul_done_i && mul_ready_o) q1.push_back({mul_tag_i, mul_data_i});
            if (lsu_done_i && lsu_ready_o) q2.push_back({lsu_tag_i, lsu_data_i});
        end
        @(posedge clk_i);
        #1;
        if (cdb_en_o) begin
            got = 1'b0;
            e   = '0;
            case (cdb_src_o)
                2'd0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                2'd1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; mul_bcast++; end
                2'd2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                default: got = 1'b0;
            endcase
            chk("sb_expected_bcast", {31'd0, got}, 32'd1);
            if (got) begin
                chk("sb_tag", {27'd0, cdb_tag_o}, {27'd0, e.tag});
                chk("sb_data", cdb_data_o, e.data);
            end
        end
        chk("alu_ready", {31'd0, alu_ready_o}, {31'd0, q0.size() < 2});
        chk("mul_ready", {31'd0, mul_ready_o}, {31'd0, q1.size() < 2});
        chk("lsu_ready", {31'd0, lsu_ready_o}, {31'd0, q2.size() < 2});
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        clear_q();
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
    endtask

    vec_t tbl[12];
    int   an, mn;
    logic acc_a, acc_m, saw_bp;

    initial begin
        tbl[0]  = '{1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd0, 2'd0};
        tbl[1]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 2'd0};
        tbl[2]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 2'd1};
        tbl[3]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'd2};
        tbl[4]  = '{1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 2'd0};
        tbl[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd0};
        tbl[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 2'd2};
        tbl[7]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0};
        tbl[8]  = '{1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 5'd8, 1'b0, 5'd0, 2'd0};
        tbl[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 2'd1};
        tbl[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd2};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0};

        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_en", {31'd0, cdb_en_o}, 32'd0);
        chk("rst_tag", {27'd0, cdb_tag_o}, 32'd0);
        chk("rst_data", cdb_data_o, 32'd0);
        chk("rst_src", {30'd0, cdb_src_o}, 32'd0);
        chk("rst_ready", {29'd0, lsu_ready_o, mul_ready_o, alu_ready_o}, 32'd7);
        reset_i = 1'b1;

        // Contention and round-robin ordering, cycle-exact.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ad, tbl[i].at, tbl[i].md, tbl[i].mt, tbl[i].ld, tbl[i].lt, 1'b0);
            step();
            chk($sformatf("tbl%0d_en", i), {31'd0, cdb_en_o}, {31'd0, tbl[i].en});
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d_tag", i), {27'd0, cdb_tag_o}, {27'd0, tbl[i].tag});
                chk($sformatf("tbl%0d_src", i), {30'd0, cdb_src_o}, {30'd0, tbl[i].src});
            end
        end

        // Single result latency and hold.
        do_reset();
        drive(1, 7, 0, 0, 0, 0, 0);
        alu_data_i = 32'hDEADBEEF;
        step();
        chk("single_c1_en", {31'd0, cdb_en_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("single_c2_en", {31'd0, cdb_en_o}, 32'd1);
        chk("single_c2_tag", {27'd0, cdb_tag_o}, 32'd7);
        chk("single_c2_data", cdb_data_o, 32'hDEADBEEF);
        chk("single_c2_src", {30'd0, cdb_src_o}, 32'd0);
        step();
        chk("single_c3_en", {31'd0, cdb_en_o}, 32'd0);
        chk("single_c3_tag", {27'd0, cdb_tag_o}, 32'd7);
        chk("single_c3_data", cdb_data_o, 32'hDEADBEEF);

        // Backpressure: ALU always valid, MUL tags 10..13 advancing only on accept.
        an = 0; mn = 0; saw_bp = 1'b0; mul_bcast = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (an >= 8 && mn >= 4 && q0.size() == 0 && q1.size() == 0) break;
            drive(an < 8, 5'(16 + an), mn < 4, 5'(10 + mn), 0, 0, 0);
            acc_a = alu_done_i && alu_ready_o;
            acc_m = mul_done_i && mul_ready_o;
            if (mul_done_i && !mul_ready_o) saw_bp = 1'b1;
            step();
            if (acc_a) an++;
            if (acc_m) mn++;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("bp_mul_ready_dropped", {31'd0, saw_bp}, 32'd1);
        chk("bp_alu_accepted", an, 8);
        chk("bp_mul_accepted", mn, 4);
        chk("bp_mul_broadcasts", mul_bcast, 4);
        chk("bp_drained", q0.size() + q1.size() + q2.size(), 0);

        // Flush drops queued entries and the same-cycle push.
        drive(1, 1, 0, 0, 1, 2, 0);
        step();
        drive(1, 3, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 9, 0, 0, 1);
        step();
        chk("flush_en", {31'd0, cdb_en_o}, 32'd0);
        chk("flush_ready", {29'd0, lsu_ready_o, mul_ready_o, alu_ready_o}, 32'd7);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("post_flush%0d_en", i), {31'd0, cdb_en_o}, 32'd0);
        end

        // Asynchronous reset between edges while a broadcast is on the bus.
        drive(1, 1, 1, 3, 0, 0, 0);
        step();
        drive(1, 2, 0, 0, 0, 0, 0);
        step();
        chk("pre_arst_en", {31'd0, cdb_en_o}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        reset_i = 1'b0;
        #1;
        chk("arst_en", {31'd0, cdb_en_o}, 32'd0);
        chk("arst_tag", {27'd0, cdb_tag_o}, 32'd0);
        chk("arst_data", cdb_data_o, 32'd0);
        chk("arst_src", {30'd0, cdb_src_o}, 32'd0);
        chk("arst_ready", {29'd0, lsu_ready_o, mul_ready_o, alu_ready_o}, 32'd7);
        clear_q();
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        drive(1, 6, 1, 5, 1, 4, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("arst_rr_src", {30'd0, cdb_src_o}, 32'd0);
        chk("arst_rr_tag", {27'd0, cdb_tag_o}, 32'd6);
        step();
        chk("arst_2nd_src", {30'd0, cdb_src_o}, 32'd1);
        step();
        chk("arst_3rd_src", {30'd0, cdb_src_o}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("arst_no_stale", {31'd0, cdb_en_o}, 32'd0);
        chk("final_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter that sits between the execution units (ALU, MUL, LSU) and the common data bus feeding the reservation station's `cdb_en_i`/`cdb_tag_i` wakeup inputs. Each unit pushes a completed result (physical destination tag plus data) into a small per-unit completion FIFO. A round-robin arbiter drains at most one entry per cycle onto a registered CDB broadcast. Per-unit ready signals give execution units backpressure when their FIFO is full.

## Interface
Parameters:
- `TAG_W`, 5, physical register tag width (matches `prd_addr` width)
- `DATA_W`, 32, result data width
- `DEPTH`, 2, entries per completion FIFO; power of two, ≥2

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `reset_i`  in  1  asynchronous, active-low reset
- `flush_i`  in  1  synchronous flush of all pending completions
- `alu_done_i`  in  1  ALU result valid
- `alu_tag_i`  in  TAG_W  ALU destination tag
- `alu_data_i`  in  DATA_W  ALU result
- `alu_ready_o`  out  1  ALU FIFO can accept
- `mul_done_i`, `mul_tag_i`, `mul_data_i`, `mul_ready_o`: same as ALU, for MUL
- `lsu_done_i`, `lsu_tag_i`, `lsu_data_i`, `lsu_ready_o`: same as ALU, for LSU
- `cdb_en_o`  out  1  broadcast valid, one cycle per result
- `cdb_tag_o`  out  TAG_W  broadcast tag
- `cdb_data_o`  out  DATA_W  broadcast data
- `cdb_src_o`  out  2  source unit: 0=ALU, 1=MUL, 2=LSU; 3 is never driven

## Operation
- Push: unit X is accepted when `X_done_i && X_ready_o && !flush_i`. `{tag, data}` is written at the FIFO tail on that edge.
- `X_ready_o = (count_X < DEPTH)`. This comes from the registered count only. It gives no credit for a same-cycle pop, so a full FIFO shows ready=0 even in the cycle it is popped.
- A push while not ready is ignored. The unit must hold `done`/`tag`/`data` until accepted.
- Arbitration each cycle uses the FIFO heads. The request vector is {non-empty ALU, MUL, LSU}.
- Round-robin pointer `rr` ∈ {0,1,2}. Priority order is rr, rr+1, rr+2 (mod 3).
- On a grant to unit k: pop head k, load the CDB registers, set `rr = (k+1) mod 3`.
- No requests: `cdb_en_o` = 0 next cycle, `rr` is unchanged, and `cdb_tag_o`/`cdb_data_o`/`cdb_src_o` hold their last values.
- Simultaneous push and pop on one FIFO: both happen and the count is unchanged.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH; it never overflows or underflows.
- `flush_i`=1 empties all FIFOs and drops any push in that cycle. `cdb_en_o` = 0 next cycle. `rr` is unchanged and no grant is made that cycle.
- Order is FIFO within a unit. There is no ordering guarantee across units beyond round-robin.

## Timing
- Reset (`reset_i`=0, asynchronous, any time including mid-operation):
  - FIFOs are emptied and `rr`=0.
  - `cdb_en_o`=0, `cdb_tag_o`=0, `cdb_data_o`=0, `cdb_src_o`=0.
  - All `X_ready_o`=1 (combinational from count=0).
- Latency: a result accepted at the edge ending cycle N arbitrates in cycle N+1. With no contention it appears on the CDB (`cdb_en_o`=1) in cycle N+2.
- There is no bypass path; minimum latency is 2 cycles.
- Throughput: one broadcast per cycle total. Each unit sustains one push per cycle only while its FIFO is not full.
- Each result is broadcast exactly once. `cdb_en_o` is high for exactly one cycle per result.
- All outputs except `X_ready_o` are registered. `X_ready_o` is a combinational decode of the registered count.

## Test plan
- Reset: hold `reset_i`=0 for 2 cycles → all CDB outputs 0; `alu_ready_o`=`mul_ready_o`=`lsu_ready_o`=1.
- Single result: ALU done tag=7, data=0xDEADBEEF accepted in cycle 0 → cycle 2: `cdb_en_o`=1, tag=7, data=0xDEADBEEF, src=0. Cycle 3: `cdb_en_o`=0, tag/data held.
- Contention: ALU/MUL/LSU done with tags 1/2/3 in the same cycle 0 → CDB shows tag 1 (src 0), tag 2 (src 1), tag 3 (src 2) in cycles 2, 3, 4. Then LSU tag 4 and ALU tag 5 are pushed together → ALU granted first (`rr`=0), then LSU.
- Backpressure (DEPTH=2):
  - Setup: ALU continuously valid; MUL done held high with tags 10, 11, 12, 13, advancing only on accept.
  - `mul_ready_o` drops after 2 queued entries.
  - All four tags are broadcast exactly once, in order 10, 11, 12, 13, interleaved round-robin with ALU.
  - No tag is lost or duplicated.
- Flush:
  - Setup: queue 2 ALU and 1 LSU entries, then assert `flush_i` for 1 cycle with `mul_done_i`=1 tag=9.
  - No further `cdb_en_o` pulses from the flushed entries.
  - Tag 9 is not broadcast.
  - All ready signals are 1 the cycle after the flush.
- Async reset mid-stream: with entries pending, drop `reset_i` between clock edges → outputs clear immediately. After release, no stale tags are broadcast and `rr` restarts at ALU.
